// File: rtl/reg16_serializer_pkg.sv
// reg16_serializer_pkg: shared state encoding, default width and counter sizing
package reg16_serializer_pkg;
    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/reg16.sv
// reg16: parallel holding register with load enable and synchronous clear
module reg16
    import reg16_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (ld)
            q <= d;
    end
endmodule

// File: rtl/reg16_serializer.sv
// reg16_serializer: ld/ready parallel-in, serial-out word transmitter
module reg16_serializer
    import reg16_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic             ready,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             sval,
    output logic             done
);
    localparam int CW = cnt_w(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             accept;
    logic [WIDTH-1:0] sr_next;

    assign last    = cnt == CW'(WIDTH - 1);
    assign accept  = ld & ready;
    assign sr_next = MSB_FIRST ? (sr << 1) : (sr >> 1);

    // outputs decode only registered state, never ld or d
    assign ready = state == ST_IDLE;
    assign sval  = state == ST_SHIFT;
    assign sout  = sval & (MSB_FIRST ? sr[WIDTH-1] : sr[0]);
    assign done  = sval & last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else if (state == ST_IDLE) begin
            if (ld) begin
                sr    <= d;
                cnt   <= '0;
                state <= ST_SHIFT;
            end
        end else begin
            sr    <= sr_next;
            cnt   <= last ? '0 : cnt + 1'b1;
            state <= last ? ST_IDLE : ST_SHIFT;
        end
    end

    reg16 #(.WIDTH(WIDTH)) u_q (
        .clk (clk),
        .rst (rst),
        .ld  (accept),
        .d   (d),
        .q   (q)
    );
endmodule

// File: tb/tb_reg16_serializer.sv
// tb_reg16_serializer: MSB- and LSB-first instances checked against a timeline model
module tb_reg16_serializer;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst, ld;
    logic [W-1:0] d;
    logic         rdy_m, sout_m, sval_m, done_m;
    logic         rdy_l, sout_l, sval_l, done_l;
    logic [W-1:0] q_m, q_l;

    int           n_tests = 0, n_fail = 0;
    int           cyc = 0, t_acc = 0, n_done = 0;
    bit           act = 1'b0;
    logic [W-1:0] w_exp = '0, q_exp = '0;

    always #5 clk = ~clk;

    reg16_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .ld(ld), .d(d), .ready(rdy_m), .q(q_m),
        .sout(sout_m), .sval(sval_m), .done(done_m)
    );

    reg16_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .ld(ld), .d(d), .ready(rdy_l), .q(q_l),
        .sout(sout_l), .sval(sval_l), .done(done_l)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // word k-th bit is on the line for edges t_acc+k .. t_acc+k+1; next accept needs W+1 edges
    task automatic step();
        int k;
        bit v;
        @(posedge clk);
        cyc++;
        if (rst) begin
            act   = 1'b0;
            q_exp = '0;
        end else if (ld && (!act || cyc - t_acc >= W + 1)) begin
            act   = 1'b1;
            t_acc = cyc;
            w_exp = d;
            q_exp = d;
        end
        #1;
        k = cyc - t_acc;
        v = act && k < W;
        check("ready_m", rdy_m, !v);
        check("sval_m", sval_m, v);
        check("sout_m", sout_m, v ? w_exp[W-1-k] : 1'b0);
        check("done_m", done_m, v && k == W - 1);
        check("q_m", q_m, q_exp);
        check("ready_l", rdy_l, !v);
        check("sval_l", sval_l, v);
        check("sout_l", sout_l, v ? w_exp[k] : 1'b0);
        check("done_l", done_l, v && k == W - 1);
        check("q_l", q_l, q_exp);
        if (done_m) n_done++;
    endtask

    task automatic send(input logic [W-1:0] w);
        ld = 1'b1;
        d  = w;
        step();
        ld = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ld = 1'b1; d = 16'hFFFF;
        repeat (2) step();
        rst = 1'b0; ld = 1'b0;
        step();
        check("rst_q", q_m, 16'h0000);

        send(16'h1234);
        check("q_1234", q_m, 16'h1234);
        repeat (17) step();

        send(16'h80A3);
        check("q_80a3", q_l, 16'h80A3);
        repeat (17) step();

        send(16'hFFFE);
        repeat (5) step();
        ld = 1'b1; d = 16'h0001;
        step();
        ld = 1'b0;
        repeat (12) step();
        check("q_ignored", q_m, 16'hFFFE);

        n_done = 0;
        ld = 1'b1; d = 16'h0001;
        step();
        d = 16'hA9B5;
        repeat (17) step();
        ld = 1'b0;
        repeat (17) step();
        check("b2b_dones", n_done, 2);
        check("q_a9b5", q_m, 16'hA9B5);

        n_done = 0;
        send(16'hFFCC);
        repeat (8) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("abort_dones", n_done, 0);
        send(16'hFFB8);
        repeat (17) step();
        check("q_ffb8", q_m, 16'hFFB8);

        repeat (3000) begin
            ld  = $urandom_range(0, 3) != 0;
            d   = W'($urandom);
            rst = $urandom_range(0, 199) == 0;
            step();
        end
        rst = 1'b0; ld = 1'b0;
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
